// File: rtl/fp8_to_fixed_decoder.sv
// fp8_to_fixed_decoder: serial 1-4-3 minifloat to signed fixed-point converter, one shift per cycle
module fp8_to_fixed_decoder #(
  parameter int OUT_W  = 19,
  parameter int FRAC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_nan,
  output logic             out_ovf,
  output logic             out_inexact
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int SH = 10 - FRAC_W;
  localparam logic [17:0] DROP_MASK = 18'((18'd1 << SH) - 18'd1);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  state_t state, state_nx;
  logic [17:0] acc;
  logic [3:0] cnt;
  logic sgn;
  logic fire_in, is_zero, is_spec, is_nan, sat;
  logic [24:0] mag;
  logic [OUT_W-1:0] mag_sat, fmt, inf_val;
  assign fire_in = in_valid && in_ready;
  assign is_zero = in_data[6:3] == 4'd0;
  assign is_spec = in_data[6:3] == 4'd15;
  assign is_nan  = is_spec && in_data[2:0] != 3'd0;
  assign inf_val = in_data[7] ? -MAX_POS : MAX_POS;
  assign mag     = 25'(acc >> SH);
  assign sat     = mag > 25'(MAX_POS);
  assign mag_sat = sat ? MAX_POS : mag[OUT_W-1:0];
  assign fmt     = sgn ? -mag_sat : mag_sat;
  // state register, frozen while ena is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nx;
  // next-state: finite inputs go through SHIFT, zero/Inf/NaN finish in one edge
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fire_in) state_nx = (is_zero || is_spec) ? DONE : SHIFT;
      SHIFT:   if (cnt == 4'd0) state_nx = DONE;
      default: if (out_ready) state_nx = IDLE;
    endcase
  end
  // handshake outputs; in_ready also dropped while reset is asserted
  always_comb begin
    in_ready  = rst_n && ena && state == IDLE;
    out_valid = state == DONE;
  end
  // datapath: load mantissa, shift by exponent, then format with truncation and saturation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      sgn         <= 1'b0;
      out_data    <= '0;
      out_nan     <= 1'b0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (fire_in) begin
      acc         <= {14'd0, 1'b1, in_data[2:0]};
      cnt         <= in_data[6:3];
      sgn         <= in_data[7];
      out_data    <= (is_spec && !is_nan) ? inf_val : '0;
      out_nan     <= is_nan;
      out_ovf     <= is_spec && !is_nan;
      out_inexact <= 1'b0;
    end else if (ena && state == SHIFT) begin
      if (cnt != 4'd0) begin
        acc <= acc << 1;
        cnt <= cnt - 4'd1;
      end else begin
        out_data    <= fmt;
        out_nan     <= 1'b0;
        out_ovf     <= sat;
        out_inexact <= |(acc & DROP_MASK);
      end
    end
endmodule
